bp_fe_queue_buffer: RTL and testbench

FE-side buffer that produces the fe_queue stream consumed by the BE checker's scheduler. It holds FE-generated queue entries and presents them to the BE with valid/yumi. It also implements the BE's speculation controls: clr (flush), roll (rewind to last committed entry) and deq (commit one issued entry). Sits between the FE pc-gen/icache output and the BE, replacing a plain FIFO.

---
 rtl/bp_fe_pkg.sv | 22 ++
 rtl/bp_fe_queue_mem.sv | 28 ++
 rtl/bp_fe_queue_buffer.sv | 122 ++++++++++++
 tb/tb_bp_fe_queue_buffer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/bp_fe_pkg.sv
// rtl/bp_fe_pkg.sv - shared types and helpers for the FE queue buffer
// Contents: pointer-width helper, speculation-control op encoding.
package bp_fe_pkg;

    // Pointers carry one extra wrap bit above the entry index.
    localparam int unsigned fq_default_els_lp = 8;

    function automatic int unsigned fq_ptr_width_f(input int unsigned els);
        return $clog2(els) + 1;
    endfunction

    localparam int unsigned fq_default_ptr_width_lp = fq_ptr_width_f(fq_default_els_lp);

    // Resolved speculation-control operation for a cycle, highest priority first.
    typedef enum logic [1:0] {
        e_fq_none = 2'd0,
        e_fq_clr  = 2'd1,
        e_fq_roll = 2'd2,
        e_fq_deq  = 2'd3
    } bp_fe_queue_op_e;

endpackage

// File: rtl/bp_fe_queue_mem.sv
// rtl/bp_fe_queue_mem.sv - els_p x width_p storage, one write port, one async read port
// Ports: clk_i; w_v_i/w_addr_i/w_data_i write port; r_addr_i/r_data_o combinational read.
module bp_fe_queue_mem
    import bp_fe_pkg::*;
#(
    parameter int width_p = 64,
    parameter int els_p   = 8
) (
    input  logic                     clk_i,
    input  logic                     w_v_i,
    input  logic [$clog2(els_p)-1:0] w_addr_i,
    input  logic [width_p-1:0]       w_data_i,
    input  logic [$clog2(els_p)-1:0] r_addr_i,
    output logic [width_p-1:0]       r_data_o
);

    logic [width_p-1:0] mem_q [els_p];

    // Contents are don't-care after reset, so the array is not reset.
    always_ff @(posedge clk_i) begin
        if (w_v_i) begin
            mem_q[w_addr_i] <= w_data_i;
        end
    end

    assign r_data_o = mem_q[r_addr_i];

endmodule

// File: rtl/bp_fe_queue_buffer.sv
// rtl/bp_fe_queue_buffer.sv - speculative FE queue with clr/roll/deq controls toward the BE
// Ports: clk_i, reset_i (sync, active-high); enq_v_i/enq_data_i/enq_ready_o FE side;
//        fe_queue_o/fe_queue_v_o/fe_queue_yumi_i BE stream; fe_queue_clr_i/roll_i/deq_i
//        speculation controls; count_o entries between committed and write pointers.
// Optional: BP_FE_QUEUE_BYPASS_EN presents an enqueued entry in the same cycle when empty.
module bp_fe_queue_buffer
    import bp_fe_pkg::*;
#(
    parameter int width_p = 64,
    parameter int els_p   = 8
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       enq_v_i,
    input  logic [width_p-1:0]         enq_data_i,
    output logic                       enq_ready_o,
    output logic [width_p-1:0]         fe_queue_o,
    output logic                       fe_queue_v_o,
    input  logic                       fe_queue_yumi_i,
    input  logic                       fe_queue_clr_i,
    input  logic                       fe_queue_roll_i,
    input  logic                       fe_queue_deq_i,
    output logic [$clog2(els_p):0]     count_o
);

    localparam int PW = fq_ptr_width_f(els_p);
    localparam int AW = PW - 1;

    logic [PW-1:0]      wptr_q, wptr_d;
    logic [PW-1:0]      rptr_q, rptr_d;
    logic [PW-1:0]      cptr_q, cptr_d;
    logic [PW-1:0]      count;
    logic               full;
    logic               enq_fire;
    logic [width_p-1:0] mem_rdata;
    bp_fe_queue_op_e    op;

    assign count    = wptr_q - cptr_q;
    assign full     = (count == PW'(els_p));
    // Depends on pointers only: a deq this cycle frees its slot next cycle.
    assign enq_ready_o = ~full;
    assign enq_fire    = enq_v_i & enq_ready_o;
    assign count_o     = count;

    always_comb begin
        op = e_fq_none;
        if (fe_queue_clr_i) begin
            op = e_fq_clr;
        end else if (fe_queue_roll_i) begin
            op = e_fq_roll;
        end else if (fe_queue_deq_i) begin
            op = e_fq_deq;
        end
    end

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cptr_d = cptr_q;
        if (fe_queue_clr_i) begin
            // Clr drops everything; a same-cycle enq handshakes but is discarded.
            cptr_d = wptr_q;
            rptr_d = wptr_q;
        end else begin
            if (enq_fire) begin
                wptr_d = wptr_q + PW'(1);
            end
            if (fe_queue_deq_i) begin
                cptr_d = cptr_q + PW'(1);
            end
            // Roll rewinds to the post-deq committed pointer and overrides yumi.
            if (fe_queue_roll_i) begin
                rptr_d = cptr_d;
            end else if (fe_queue_yumi_i) begin
                rptr_d = rptr_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cptr_q <= cptr_d;
        end
    end

    bp_fe_queue_mem #(
        .width_p (width_p),
        .els_p   (els_p)
    ) mem (
        .clk_i    (clk_i),
        .w_v_i    (enq_fire & ~fe_queue_clr_i & ~reset_i),
        .w_addr_i (wptr_q[AW-1:0]),
        .w_data_i (enq_data_i),
        .r_addr_i (rptr_q[AW-1:0]),
        .r_data_o (mem_rdata)
    );

`ifdef BP_FE_QUEUE_BYPASS_EN
    // Entry is still written to storage, so a later roll can replay it.
    logic bypass_hit;
    assign bypass_hit   = (rptr_q == wptr_q) & enq_fire & ~fe_queue_clr_i;
    assign fe_queue_v_o = (rptr_q != wptr_q) | bypass_hit;
    assign fe_queue_o   = bypass_hit ? enq_data_i : mem_rdata;
`else
    assign fe_queue_v_o = (rptr_q != wptr_q);
    assign fe_queue_o   = mem_rdata;
`endif

`ifndef SYNTHESIS
    a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i)
        fe_queue_yumi_i |-> fe_queue_v_o);
    a_deq_needs_issued: assert property (@(posedge clk_i) disable iff (reset_i)
        (fe_queue_deq_i && op != e_fq_clr) |-> (cptr_q != rptr_q));
`endif

endmodule

// File: tb/tb_bp_fe_queue_buffer.sv
// tb/tb_bp_fe_queue_buffer.sv - directed self-checking bench for bp_fe_queue_buffer
module tb_bp_fe_queue_buffer;

    localparam int W = 8;
    localparam int N = 4;

    logic         clk_i = 1'b0;
    logic         reset_i;
    logic         enq_v_i;
    logic [W-1:0] enq_data_i;
    logic         enq_ready_o;
    logic [W-1:0] fe_queue_o;
    logic         fe_queue_v_o;
    logic         fe_queue_yumi_i;
    logic         fe_queue_clr_i;
    logic         fe_queue_roll_i;
    logic         fe_queue_deq_i;
    logic [2:0]   count_o;

    int errors = 0;
    int checks = 0;

    bp_fe_queue_buffer #(.width_p(W), .els_p(N)) dut (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .enq_v_i         (enq_v_i),
        .enq_data_i      (enq_data_i),
        .enq_ready_o     (enq_ready_o),
        .fe_queue_o      (fe_queue_o),
        .fe_queue_v_o    (fe_queue_v_o),
        .fe_queue_yumi_i (fe_queue_yumi_i),
        .fe_queue_clr_i  (fe_queue_clr_i),
        .fe_queue_roll_i (fe_queue_roll_i),
        .fe_queue_deq_i  (fe_queue_deq_i),
        .count_o         (count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic next();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        enq_v_i         = 1'b0;
        enq_data_i      = '0;
        fe_queue_yumi_i = 1'b0;
        fe_queue_clr_i  = 1'b0;
        fe_queue_roll_i = 1'b0;
        fe_queue_deq_i  = 1'b0;
    endtask

    initial begin
        reset_i = 1'b1;
        idle();
        next();
        next();
        reset_i = 1'b0;
        #1;
        chk("reset_v", fe_queue_v_o, 0);
        chk("reset_ready", enq_ready_o, 1);
        chk("reset_count", count_o, 0);

        // Basic enq/yumi with 1-cycle latency
        enq_v_i = 1'b1; enq_data_i = 8'h11; #1;
`ifndef BP_FE_QUEUE_BYPASS_EN
        chk("t1_no_bypass_v", fe_queue_v_o, 0);
`endif
        next();
        enq_data_i = 8'h22; #1;
        chk("t1_v_after_enq", fe_queue_v_o, 1);
        chk("t1_data_11", fe_queue_o, 8'h11);
        next();
        idle(); fe_queue_yumi_i = 1'b1; #1;
        chk("t1_yumi_11", fe_queue_o, 8'h11);
        next(); #1;
        chk("t1_yumi_22", fe_queue_o, 8'h22);
        next();
        idle(); #1;
        chk("t1_v_drained", fe_queue_v_o, 0);
        chk("t1_count_uncommitted", count_o, 2);

        fe_queue_clr_i = 1'b1;
        next();
        idle(); #1;
        chk("clr_count", count_o, 0);

        // Fill, full with simultaneous deq, wrap
        for (int i = 0; i < 4; i++) begin
            enq_v_i = 1'b1; enq_data_i = 8'hA0 + 8'(i);
            next();
        end
        idle(); #1;
        chk("t2_full_ready", enq_ready_o, 0);
        chk("t2_full_count", count_o, 4);
        fe_queue_yumi_i = 1'b1;
        next();
        idle();
        fe_queue_deq_i = 1'b1; enq_v_i = 1'b1; enq_data_i = 8'hA4; #1;
        chk("t2_deq_full_ready", enq_ready_o, 0);
        next();
        fe_queue_deq_i = 1'b0; #1;
        chk("t2_freed_ready", enq_ready_o, 1);
        chk("t2_freed_count", count_o, 3);
        next();
        idle(); #1;
        chk("t2_count_after_a4", count_o, 4);
        fe_queue_yumi_i = 1'b1;
        for (int i = 1; i < 5; i++) begin
            #1;
            chk($sformatf("t2_read_%0d", i), fe_queue_o, 8'hA0 + 8'(i));
            next();
        end
        idle(); #1;
        chk("t2_drained_v", fe_queue_v_o, 0);
        fe_queue_clr_i = 1'b1;
        next();
        idle();

        // Roll and roll+deq
        for (int i = 1; i <= 3; i++) begin
            enq_v_i = 1'b1; enq_data_i = 8'(i);
            next();
        end
        idle();
        fe_queue_yumi_i = 1'b1;
        next(); next(); next();
        idle();
        fe_queue_deq_i = 1'b1;
        next();
        idle(); fe_queue_roll_i = 1'b1;
        next();
        idle(); #1;
        chk("t3_roll_v", fe_queue_v_o, 1);
        chk("t3_roll_data", fe_queue_o, 8'h02);
        fe_queue_yumi_i = 1'b1;
        next();
        idle(); fe_queue_roll_i = 1'b1; fe_queue_deq_i = 1'b1;
        next();
        idle(); #1;
        chk("t3_rolldeq_data", fe_queue_o, 8'h03);
        chk("t3_rolldeq_count", count_o, 1);

        // Clr beats simultaneous enq/yumi/deq
        enq_v_i = 1'b1; enq_data_i = 8'h04; next();
        enq_data_i = 8'h05; next();
        idle(); fe_queue_yumi_i = 1'b1; next();
        idle(); #1;
        chk("t4_count_before", count_o, 3);
        fe_queue_clr_i = 1'b1; enq_v_i = 1'b1; enq_data_i = 8'h55;
        fe_queue_yumi_i = 1'b1; fe_queue_deq_i = 1'b1;
        next();
        idle(); #1;
        chk("t4_clr_count", count_o, 0);
        chk("t4_clr_v", fe_queue_v_o, 0);
        chk("t4_clr_ready", enq_ready_o, 1);
        next();
        chk("t4_55_never", fe_queue_v_o, 0);

        // Reset mid-stream
        enq_v_i = 1'b1; enq_data_i = 8'h66; next();
        enq_data_i = 8'h67; next();
        idle(); #1;
        chk("t5_count_before", count_o, 2);
        reset_i = 1'b1; enq_v_i = 1'b1; enq_data_i = 8'h68; fe_queue_yumi_i = 1'b1;
        next();
        reset_i = 1'b0; idle(); #1;
        chk("t5_rst_count", count_o, 0);
        chk("t5_rst_v", fe_queue_v_o, 0);
        chk("t5_rst_ready", enq_ready_o, 1);
        enq_v_i = 1'b1; enq_data_i = 8'h77;
        next();
        idle(); #1;
        chk("t5_77_v", fe_queue_v_o, 1);
        chk("t5_77_data", fe_queue_o, 8'h77);
        fe_queue_clr_i = 1'b1;
        next();
        idle();

        // Empty-queue enq: bypass vs. strict latency
`ifdef BP_FE_QUEUE_BYPASS_EN
        enq_v_i = 1'b1; enq_data_i = 8'h99; fe_queue_yumi_i = 1'b1; #1;
        chk("t6_bypass_v", fe_queue_v_o, 1);
        chk("t6_bypass_data", fe_queue_o, 8'h99);
        next();
        idle(); #1;
        chk("t6_bypass_consumed", fe_queue_v_o, 0);
        fe_queue_roll_i = 1'b1;
        next();
        idle(); #1;
        chk("t6_replay_v", fe_queue_v_o, 1);
        chk("t6_replay_data", fe_queue_o, 8'h99);
`else
        enq_v_i = 1'b1; enq_data_i = 8'h99; #1;
        chk("t6_no_bypass_v", fe_queue_v_o, 0);
        next();
        idle(); #1;
        chk("t6_late_v", fe_queue_v_o, 1);
        chk("t6_late_data", fe_queue_o, 8'h99);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
